// File: rtl/mem_responder_if.sv
// Processor-side bus of the wait-state memory responder.
// The master drives a request; the slave answers with a one-cycle ready pulse.
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata,
    input  ready, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rdata, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder with programmable wait states.
// Requests are taken in IDLE, held for WAIT_CYCLES cycles in WAIT, and
// completed by a single DONE cycle that pulses ready (qualified by err).
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  mem_responder_if.slave   bus
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            capture;

  // Captured request (data registers, no reset needed)
  logic            we_q;
  logic            err_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;

  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     mem_q [DEPTH_WORDS];

  // Request decode straight from the bus
  logic            req_err;
  logic [AW-1:0]   req_idx;

  // Access actually being completed (bus when finishing from IDLE, else captured)
  logic            acc_we;
  logic            acc_err;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_wdata;
  logic            enter_done;

  assign req_idx = bus.addr[AW+1:2];
  assign req_err = (bus.addr[1:0] != 2'b00) | (|bus.addr[31:AW+2]);

  // Next-state and wait-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Select which request is finishing; with zero wait states it is the one on the bus
  always_comb begin
    acc_we    = we_q;
    acc_err   = err_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      acc_we    = bus.we;
      acc_err   = req_err;
      acc_idx   = req_idx;
      acc_wdata = bus.wdata;
    end
  end

  assign enter_done = (state_d == S_DONE) && (state_q != S_DONE);

  // Read data: loaded on the edge entering DONE, zero for rejected accesses
  always_comb begin
    rdata_d = rdata_q;
    if (enter_done) begin
      if (acc_err) begin
        rdata_d = 32'h0;
      end else if (!acc_we) begin
        rdata_d = mem_q[acc_idx];
      end
    end
  end

  // Control state, counter and read data register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Request capture registers
  always_ff @(posedge clk) begin
    if (capture) begin
      we_q    <= bus.we;
      err_q   <= req_err;
      idx_q   <= req_idx;
      wdata_q <= bus.wdata;
    end
  end

  // Storage: never cleared; a write commits only on a DONE-entering edge out of reset
  always_ff @(posedge clk) begin
    if (reset && enter_done && acc_we && !acc_err) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign bus.ready = (state_q == S_DONE);
  assign bus.err   = (state_q == S_DONE) & err_q;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.rdata = rdata_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words of storage; power of two, 4..65536.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before each response, 0..15.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous reset, active-low.
REQ-005 Port req, input, 1: processor requests an access; sampled only in IDLE.
REQ-006 Port we, input, 1: 1 = write, 0 = read; sampled with req.
REQ-007 Port addr, input, 32: byte address; sampled with req.
REQ-008 Port wdata, input, 32: write data; sampled with req.
REQ-009 Port ready, output, 1: one-cycle pulse marking access completion.
REQ-010 Port rdata, output, 32: read data; valid when ready=1, held until the next ready.
REQ-011 Port err, output, 1: qualifies ready; 1 = access rejected (misaligned or out of range).
REQ-012 Port busy, output, 1: 1 whenever the FSM is not in IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT, DONE.
REQ-014 In IDLE, req=1 at a rising edge SHALL capture we, addr, wdata into internal registers and leave IDLE.
REQ-015 On capture, the next state SHALL be WAIT with the wait counter loaded to WAIT_CYCLES-1, or DONE directly when WAIT_CYCLES=0.
REQ-016 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL move to DONE on the edge where the counter is 0.
REQ-017 ready SHALL be 1 for exactly the one cycle spent in DONE; DONE SHALL always return to IDLE on the next edge.
REQ-018 Latency: ready SHALL rise WAIT_CYCLES+1 edges after the capturing edge.
REQ-019 req, we, addr, wdata SHALL be ignored while busy=1 or in DONE; a request held high through DONE is accepted on the first IDLE edge after.
REQ-020 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2].
REQ-021 The access SHALL be flagged err=1 if addr[1:0]!=0 or addr >= 4*DEPTH_WORDS.
REQ-022 A valid write SHALL commit wdata to memory on the edge that enters DONE; rdata SHALL keep its previous value.
REQ-023 A valid read SHALL load rdata from the addressed word on the edge that enters DONE.
REQ-024 An err access SHALL perform no write and SHALL drive rdata=0.
REQ-025 A read issued after a completed write to the same word SHALL return the written data.
REQ-026 err SHALL be 0 whenever ready=0.
REQ-027 Storage contents SHALL NOT be cleared by reset and are undefined until written.

Reset
REQ-028 While reset=0, the FSM SHALL be IDLE and ready=0, err=0, busy=0, rdata=32'h0, counter=0, without waiting for a clock edge.
REQ-029 If reset asserts during WAIT or before the DONE-entering edge, the pending access SHALL be abandoned with no memory write.
REQ-030 After reset deasserts, the first rising edge with req=1 SHALL be accepted normally.

Verification
REQ-031 Write 32'hDEADBEEF to addr 0x10, then read 0x10 (WAIT_CYCLES=2) -> ready one cycle, 3 edges after each capture; rdata=32'hDEADBEEF; err=0.
REQ-032 Read addr 0x13 (misaligned), then read 0x400 with DEPTH_WORDS=256 -> both complete with ready=1, err=1, rdata=0; a following read of 0x10 still returns 32'hDEADBEEF.
REQ-033 WAIT_CYCLES=0, req held high for 6 cycles with reads of 0x0 -> ready pulses every 2nd cycle; busy=1 in DONE; no request lost or duplicated.
REQ-034 Write 32'h12345678 to 0x20, assert reset=0 mid-WAIT, release, read 0x20 -> outputs zero immediately on reset; rdata != 32'h12345678 unless previously written (write abandoned).
REQ-035 Toggle we/addr/wdata during WAIT of a write to 0x30 with 32'hA5A5A5A5 -> memory[0x30] = 32'hA5A5A5A5; no other word changed.
REQ-036 Back-to-back write 0x40 = 32'h1, read 0x40, write 0x40 = 32'h2, read 0x40 -> reads return 32'h1, then 32'h2.
